// File: rtl/pwm_monitor_if.sv
// Signal bundle between a PWM line monitor and whatever drives its time base and reads its results.
// Handshake: valid is a one-cycle strobe with no ready; width/phase/stuck are stable while valid is high and hold until the next strobe.
interface pwm_monitor_if;
  logic [8:0] time_cnt;
  logic       pwm_in;
  logic       en;
  logic [8:0] width_out;
  logic [7:0] phase_out;
  logic       stuck_out;
  logic       valid;
  logic [1:0] state_dbg;

  modport master (
    output time_cnt, pwm_in, en,
    input  width_out, phase_out, stuck_out, valid, state_dbg
  );

  modport slave (
    input  time_cnt, pwm_in, en,
    output width_out, phase_out, stuck_out, valid, state_dbg
  );
endinterface

// File: rtl/pwm_monitor.sv
// Measures the width and centre phase of one PWM line against the shared carrier time counter.
// Also flags lines that stay low (dead) or stay high (stuck) for a whole carrier period.
module pwm_monitor #(
  parameter int CYCLE          = 512,
  parameter bit PHASE_INVERTED = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  pwm_monitor_if.slave bus
);

  localparam int              TW      = $clog2(CYCLE);
  localparam logic [TW-1:0]   TMO_MAX = TW'(CYCLE - 1);
  localparam logic [9:0]      CYC10   = 10'(CYCLE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    WAIT_FALL = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          pwm_q;
  logic          rise, fall, tmo_hit;
  logic [TW-1:0] tmo;
  logic [8:0]    tr;
  logic [8:0]    width_r;
  logic [7:0]    phase_r;
  logic          stuck_r, valid_r;

  logic          capture, report_meas, report_tmo, tmo_clr, tmo_stuck;
  logic [9:0]    w_sum, p_sum;
  logic [8:0]    w_mod, p_mod;
  logic [7:0]    phase_calc;

  assign rise    = bus.pwm_in & ~pwm_q;
  assign fall    = ~bus.pwm_in & pwm_q;
  assign tmo_hit = (tmo == TMO_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Dropping EN is checked first in every state so an abort always beats an edge or timeout.
  always_comb begin
    state_nx    = state;
    capture     = 1'b0;
    report_meas = 1'b0;
    report_tmo  = 1'b0;
    tmo_clr     = 1'b0;
    tmo_stuck   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en) begin
          state_nx = WAIT_RISE;
          tmo_clr  = 1'b1;
        end
      end
      WAIT_RISE: begin
        if (!bus.en) begin
          state_nx = IDLE;
        end else if (rise) begin
          capture  = 1'b1;
          tmo_clr  = 1'b1;
          state_nx = WAIT_FALL;
        end else if (tmo_hit) begin
          report_tmo = 1'b1;
          tmo_stuck  = pwm_q;
          tmo_clr    = 1'b1;
        end else if (fall) begin
          tmo_clr = 1'b1;
        end
      end
      WAIT_FALL: begin
        if (!bus.en) begin
          state_nx = IDLE;
        end else if (fall) begin
          report_meas = 1'b1;
          tmo_clr     = 1'b1;
          state_nx    = WAIT_RISE;
        end else if (tmo_hit) begin
          report_tmo = 1'b1;
          tmo_stuck  = 1'b1;
          tmo_clr    = 1'b1;
          state_nx   = WAIT_RISE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Width and centre are taken modulo the carrier period so pulses spanning the wrap measure correctly.
  always_comb begin
    w_sum = {1'b0, bus.time_cnt} - {1'b0, tr};
    if (bus.time_cnt < tr) w_sum = w_sum + CYC10;
    p_sum = {1'b0, tr} + (w_sum >> 1);
    if (p_sum >= CYC10) p_sum = p_sum - CYC10;
    w_mod = w_sum[8:0];
    p_mod = p_sum[8:0];
    phase_calc = PHASE_INVERTED ? (8'hFF - p_mod[8:1]) : p_mod[8:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q   <= 1'b0;
      tmo     <= '0;
      tr      <= '0;
      width_r <= '0;
      phase_r <= '0;
      stuck_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      pwm_q   <= bus.pwm_in;
      valid_r <= report_meas | report_tmo;
      if (tmo_clr)            tmo <= '0;
      else if (state != IDLE) tmo <= tmo + TW'(1);
      if (capture) tr <= bus.time_cnt;
      if (report_meas) begin
        width_r <= w_mod;
        phase_r <= phase_calc;
        stuck_r <= 1'b0;
      end else if (report_tmo) begin
        width_r <= '0;
        phase_r <= '0;
        stuck_r <= tmo_stuck;
      end
    end
  end

  assign bus.width_out = width_r;
  assign bus.phase_out = phase_r;
  assign bus.stuck_out = stuck_r;
  assign bus.valid     = valid_r;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_pwm_monitor.sv
// Directed and randomised pulse trains applied to a normal and a phase-inverted monitor in parallel;
// each expected result is derived from the pulse's rise time and length and queued with the cycle it is due.
module tb_pwm_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] tcnt;
  logic       pwm;
  logic       en;

  always #5 clk = ~clk;

  pwm_monitor_if bus_n ();
  pwm_monitor_if bus_i ();

  assign bus_n.time_cnt = tcnt;
  assign bus_n.pwm_in   = pwm;
  assign bus_n.en       = en;
  assign bus_i.time_cnt = tcnt;
  assign bus_i.pwm_in   = pwm;
  assign bus_i.en       = en;

  pwm_monitor #(.CYCLE(512), .PHASE_INVERTED(1'b0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));
  pwm_monitor #(.CYCLE(512), .PHASE_INVERTED(1'b1)) dut_i (.clk(clk), .rst_n(rst_n), .bus(bus_i));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Entry layout: {due cycle[49:18], width[17:9], phase[8:1], stuck[0]}
  logic [49:0] exp_q[$];
  logic [8:0]  last_w  = '0;
  logic [7:0]  last_p  = '0;
  logic [7:0]  last_pi = '0;
  logic        last_s  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic expect_pulse(input int fall_cyc, input int rise_time, input int w);
    int p;
    p = (rise_time + w / 2) % 512;
    exp_q.push_back({32'(fall_cyc), 9'(w), 8'(p / 2), 1'b0});
  endtask

  task automatic expect_tmo(input int due_cyc, input logic s);
    exp_q.push_back({32'(due_cyc), 9'd0, 8'd0, s});
  endtask

  task automatic check_outputs();
    logic [49:0] e;
    logic        due;
    due = 1'b0;
    if (!rst_n) begin
      last_w  = '0;
      last_p  = '0;
      last_pi = '0;
      last_s  = 1'b0;
      chk("state_rst", 32'(bus_n.state_dbg), 32'd0);
    end
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      due = (e[49:18] == 32'(cyc));
    end
    chk("valid", 32'(bus_n.valid), 32'(due));
    chk("valid_inv", 32'(bus_i.valid), 32'(due));
    if (due) begin
      e = exp_q.pop_front();
      last_w  = e[17:9];
      last_p  = e[8:1];
      last_pi = (e[17:9] != 9'd0) ? (8'hFF - e[8:1]) : 8'h00;
      last_s  = e[0];
    end
    chk("width", 32'(bus_n.width_out), 32'(last_w));
    chk("phase", 32'(bus_n.phase_out), 32'(last_p));
    chk("stuck", 32'(bus_n.stuck_out), 32'(last_s));
    chk("phase_inv", 32'(bus_i.phase_out), 32'(last_pi));
  endtask

  task automatic tick(input logic lvl);
    tcnt = 9'(cyc % 512);
    pwm  = lvl;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    cyc++;
  endtask

  task automatic run_to(input int t, input logic lvl);
    while ((cyc % 512) != t) tick(lvl);
  endtask

  initial begin
    int gap, hi, r, e0;
    rst_n = 1'b0;
    en    = 1'b0;
    pwm   = 1'b0;
    tcnt  = '0;
    @(negedge clk);
    repeat (3) tick(1'b0);
    rst_n = 1'b1;
    repeat (2) tick(1'b0);

    // Spec examples: plain, odd width, wrapping pulse
    en = 1'b1;
    run_to(78, 1'b0);
    expect_pulse(cyc + 100, 78, 100);
    run_to(178, 1'b1);
    run_to(78, 1'b0);
    expect_pulse(cyc + 101, 78, 101);
    run_to(179, 1'b1);
    run_to(466, 1'b0);
    expect_pulse(cyc + 100, 466, 100);
    run_to(54, 1'b1);

    // Random pulse train, including back-to-back pulses with a single low cycle
    for (int k = 0; k < 24; k++) begin
      gap = (k % 4 == 0) ? 1 : int'($urandom_range(1, 300));
      hi  = int'($urandom_range(1, 300));
      repeat (gap) tick(1'b0);
      expect_pulse(cyc + hi, cyc % 512, hi);
      repeat (hi) tick(1'b1);
    end
    tick(1'b0);

    // Dead line: timeouts every carrier period
    en = 1'b0;
    repeat (3) tick(1'b0);
    en = 1'b1;
    e0 = cyc;
    expect_tmo(e0 + 512, 1'b0);
    expect_tmo(e0 + 1024, 1'b0);
    repeat (1100) tick(1'b0);

    // Enable mid-pulse: first pulse ignored, next one measured
    en = 1'b0;
    run_to(78, 1'b0);
    run_to(100, 1'b1);
    en = 1'b1;
    run_to(178, 1'b1);
    run_to(78, 1'b0);
    expect_pulse(cyc + 100, 78, 100);
    run_to(178, 1'b1);

    // Stuck high
    run_to(200, 1'b0);
    r = cyc;
    expect_tmo(r + 512, 1'b1);
    repeat (600) tick(1'b1);
    repeat (20) tick(1'b0);

    // EN dropped during WAIT_FALL: no result, outputs hold
    run_to(78, 1'b0);
    run_to(120, 1'b1);
    en = 1'b0;
    tick(1'b1);
    en = 1'b1;
    run_to(178, 1'b1);
    tick(1'b0);

    // EN dropped on the very fall cycle: abort wins
    run_to(78, 1'b0);
    run_to(178, 1'b1);
    en = 1'b0;
    tick(1'b0);
    en = 1'b1;

    // Reset pulse during WAIT_FALL
    run_to(78, 1'b0);
    run_to(120, 1'b1);
    rst_n = 1'b0;
    tick(1'b1);
    rst_n = 1'b1;
    run_to(178, 1'b1);
    repeat (5) tick(1'b0);

    // Measurement resumes after reset
    run_to(78, 1'b0);
    expect_pulse(cyc + 100, 78, 100);
    run_to(178, 1'b1);
    repeat (5) tick(1'b0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
